gpi_sticky: RTL and testbench

Parametrised general-purpose input block with two independent I2C read ports.
- Each external input bus is synchronised, optionally debounced, and latched into per-bit sticky change flags that clear when read.
- A registered interrupt output reports any pending flag.
- Sits behind the I2C slave decoders in the same position as the existing fixed 16×8 GPI bank, replacing it where change notification is required.

---
 rtl/gpi_sticky.sv | 216 +++++++++++++++++++++
 tb/tb_gpi_sticky.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gpi_sticky.sv
// ---------------------------------------------------------------------------
// gpi_sticky
//   General-purpose input bank with sticky per-bit change flags and two
//   independent I2C read ports. Each DIN bit is synchronised, optionally
//   debounced, edge-detected and latched into a change flag. A read of a
//   flag register clears it. IRQ reports any pending flag.
//
// Optional feature:
//   GPI_DEBOUNCE_EN  - when defined, each bit passes through a stability
//                      filter of DEB_LIMIT cycles before reaching FILT.
//
// Parameters:
//   DW           bits per input register
//   NREG         number of input registers
//   SYNC_STAGES  synchroniser depth (2..4)
//   DEB_LIMIT    debounce stability count (2..255, debounce build only)
//
// Ports:
//   SYSCLK       system clock, rising edge
//   RESET_N      synchronous active-low reset
//   PORT_CSx     port x select
//   OFFSET_SELx  port x one-hot select: [NREG-1:0] live, [2*NREG-1:NREG] flag
//   RD_WRx       port x direction, 1 = read (writes ignored)
//   DIN          raw asynchronous inputs, register k = DIN[k*DW +: DW]
//   DOUTx        port x read data (registered, holds between reads)
//   IRQ          registered, high while any change flag is set
// ---------------------------------------------------------------------------
module gpi_sticky #(
    parameter int unsigned DW          = 8,
    parameter int unsigned NREG        = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_LIMIT   = 4
) (
    input  logic                 SYSCLK,
    input  logic                 RESET_N,
    input  logic                 PORT_CS1,
    input  logic [2*NREG-1:0]    OFFSET_SEL1,
    input  logic                 RD_WR1,
    input  logic                 PORT_CS2,
    input  logic [2*NREG-1:0]    OFFSET_SEL2,
    input  logic                 RD_WR2,
    input  logic [NREG*DW-1:0]   DIN,
    output logic [DW-1:0]        DOUT1,
    output logic [DW-1:0]        DOUT2,
    output logic                 IRQ
);

    localparam int unsigned NBIT   = NREG * DW;
    localparam int unsigned SYNC_W = SYNC_STAGES * NBIT;

    // Elaboration-time guard on the legal parameter ranges.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEB_LIMIT < 2 || DEB_LIMIT > 255)
    begin : g_param_range_err
        $error("gpi_sticky: SYNC_STAGES or DEB_LIMIT out of range");
    end

    // -----------------------------------------------------------------------
    // Read decode
    // -----------------------------------------------------------------------
    logic rd1_c;
    logic rd2_c;

    assign rd1_c = PORT_CS1 & RD_WR1;
    assign rd2_c = PORT_CS2 & RD_WR2;

    // OR of every selected live and flag register.
    function automatic logic [DW-1:0] sel_or(
        input logic [2*NREG-1:0] sel,
        input logic [NBIT-1:0]   live,
        input logic [NBIT-1:0]   flg
    );
        logic [DW-1:0] acc;
        acc = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            if (sel[k]) begin
                acc = acc | live[k*DW +: DW];
            end
            if (sel[NREG + k]) begin
                acc = acc | flg[k*DW +: DW];
            end
        end
        return acc;
    endfunction

    // -----------------------------------------------------------------------
    // Synchroniser: stage 0 in the low slice, synced value in the top slice
    // -----------------------------------------------------------------------
    logic [SYNC_W-1:0] sync_q;
    logic [SYNC_W-1:0] sync_d;
    logic [NBIT-1:0]   synced_c;

    always_comb begin
        sync_d = {sync_q[SYNC_W-NBIT-1:0], DIN};
    end

    assign synced_c = sync_q[SYNC_W-1 -: NBIT];

    // -----------------------------------------------------------------------
    // Filtered value
    // -----------------------------------------------------------------------
    logic [NBIT-1:0] filt_c;

`ifdef GPI_DEBOUNCE_EN
    localparam int unsigned CNT_W   = $clog2(DEB_LIMIT);
    localparam int unsigned CNT_TOT = NBIT * CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_LIMIT - 1);

    logic [NBIT-1:0]    filt_q;
    logic [NBIT-1:0]    filt_d;
    logic [CNT_TOT-1:0] cnt_q;
    logic [CNT_TOT-1:0] cnt_d;

    // Per-bit stability counter; FILT follows synced only after the
    // mismatch has persisted DEB_LIMIT consecutive cycles.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int unsigned b = 0; b < NBIT; b++) begin
            if (synced_c[b] != filt_q[b]) begin
                if (cnt_q[b*CNT_W +: CNT_W] == CNT_MAX) begin
                    filt_d[b] = synced_c[b];
                end else begin
                    cnt_d[b*CNT_W +: CNT_W] = cnt_q[b*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!RESET_N) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_c = filt_q;
`else
    assign filt_c = synced_c;
`endif

    // -----------------------------------------------------------------------
    // Edge detect and sticky flags
    // -----------------------------------------------------------------------
    logic [NBIT-1:0] filt_dly_q;
    logic [NBIT-1:0] filt_dly_d;
    logic [NBIT-1:0] chg_c;
    logic [NBIT-1:0] clr_c;
    logic [NBIT-1:0] flag_q;
    logic [NBIT-1:0] flag_d;

    assign filt_dly_d = filt_c;
    assign chg_c      = filt_c ^ filt_dly_q;

    // A flag register is cleared when either port reads it; a coincident
    // change sets the bit again, so set wins over clear.
    always_comb begin
        clr_c = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            clr_c[k*DW +: DW] = {DW{(rd1_c & OFFSET_SEL1[NREG + k]) |
                                    (rd2_c & OFFSET_SEL2[NREG + k])}};
        end
        flag_d = (flag_q & ~clr_c) | chg_c;
    end

    // -----------------------------------------------------------------------
    // Read data and interrupt
    // -----------------------------------------------------------------------
    logic [DW-1:0] dout1_q;
    logic [DW-1:0] dout1_d;
    logic [DW-1:0] dout2_q;
    logic [DW-1:0] dout2_d;
    logic          irq_q;
    logic          irq_d;

    // Both ports see the pre-clear flag value on a shared read edge.
    always_comb begin
        dout1_d = dout1_q;
        dout2_d = dout2_q;
        if (rd1_c) begin
            dout1_d = sel_or(OFFSET_SEL1, filt_c, flag_q);
        end
        if (rd2_c) begin
            dout2_d = sel_or(OFFSET_SEL2, filt_c, flag_q);
        end
        irq_d = |flag_q;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge SYSCLK) begin
        if (!RESET_N) begin
            sync_q     <= '0;
            filt_dly_q <= '0;
            flag_q     <= '0;
            dout1_q    <= '0;
            dout2_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            filt_dly_q <= filt_dly_d;
            flag_q     <= flag_d;
            dout1_q    <= dout1_d;
            dout2_q    <= dout2_d;
            irq_q      <= irq_d;
        end
    end

    assign DOUT1 = dout1_q;
    assign DOUT2 = dout2_q;
    assign IRQ   = irq_q;

endmodule

// File: tb/tb_gpi_sticky.sv
// ---------------------------------------------------------------------------
// tb_gpi_sticky
//   Directed bench for gpi_sticky at default parameters. Expected values
//   are hand-computed constants; edge offsets derive from LAT, the edge at
//   which a change stable before E0 appears in FLAG and in live reads.
// ---------------------------------------------------------------------------
module tb_gpi_sticky;

    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 16;
`ifdef GPI_DEBOUNCE_EN
    localparam int LAT = 2 + 4;
`else
    localparam int LAT = 2;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cs1, rd1, cs2, rd2;
    logic [2*NREG-1:0]    sel1, sel2;
    logic [NREG*DW-1:0]   din;
    logic [DW-1:0]        dout1, dout2;
    logic                 irq;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gpi_sticky u_dut (
        .SYSCLK      (clk),
        .RESET_N     (rst_n),
        .PORT_CS1    (cs1),
        .OFFSET_SEL1 (sel1),
        .RD_WR1      (rd1),
        .PORT_CS2    (cs2),
        .OFFSET_SEL2 (sel2),
        .RD_WR2      (rd2),
        .DIN         (din),
        .DOUT1       (dout1),
        .DOUT2       (dout2),
        .IRQ         (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs1 = 1'b0; rd1 = 1'b0; sel1 = '0;
        cs2 = 1'b0; rd2 = 1'b0; sel2 = '0;
    endtask

    task automatic rd_p1(input int idx);
        cs1 = 1'b1; rd1 = 1'b1; sel1 = '0; sel1[idx] = 1'b1;
    endtask

    task automatic rd_p2(input int idx);
        cs2 = 1'b1; rd2 = 1'b1; sel2 = '0; sel2[idx] = 1'b1;
    endtask

    task automatic set_reg(input int k, input logic [DW-1:0] v);
        din[k*DW +: DW] = v;
    endtask

    initial begin
        idle();
        din   = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_irq",   32'(irq),   32'h0);
        check("rst_dout1", 32'(dout1), 32'h0);
        check("rst_dout2", 32'(dout2), 32'h0);
        rst_n = 1'b1;
        repeat (LAT + 3) step();

        // Quiet inputs: live and flag reads return zero
        rd_p1(3); step(); idle();
        check("live3", 32'(dout1), 32'h00);
        rd_p1(NREG + 3); step(); idle();
        check("flag3", 32'(dout1), 32'h00);
        check("irq_idle", 32'(irq), 32'h0);

        // Register 5 change: flag, live read, IRQ rise and fall
        set_reg(5, 8'hA5);
        step();                                   // E0
        repeat (LAT - 2) step();
        rd_p2(NREG + 5); step(); idle();          // E0+LAT-1
        check("flag5_early", 32'(dout2), 32'h00);
        rd_p1(5); step(); idle();                 // E0+LAT
        check("live5", 32'(dout1), 32'hA5);
        check("irq_pre", 32'(irq), 32'h0);
        step();                                   // E0+LAT+1
        check("irq_rise", 32'(irq), 32'h1);
        rd_p2(NREG + 5); step(); idle();          // clear edge
        check("flag5", 32'(dout2), 32'hA5);
        check("irq_at_clr", 32'(irq), 32'h1);
        rd_p2(NREG + 5); step(); idle();
        check("flag5_cleared", 32'(dout2), 32'h00);
        check("irq_fall", 32'(irq), 32'h0);

        // Writes and deselected reads leave DOUT unchanged
        cs1 = 1'b1; rd1 = 1'b0; sel1 = '0; sel1[3] = 1'b1;
        step(); idle();
        check("write_ignored", 32'(dout1), 32'hA5);
        cs1 = 1'b0; rd1 = 1'b1; sel1 = '0; sel1[3] = 1'b1;
        step(); idle();
        check("no_cs_hold", 32'(dout1), 32'hA5);

        // Same-edge set and clear on flag register 2
        set_reg(2, 8'h03);
        repeat (LAT + 3) step();
        check("irq_flag2", 32'(irq), 32'h1);
        set_reg(2, 8'h02);                        // bit 0 falls
        step();                                   // B
        repeat (LAT - 1) step();
        rd_p1(NREG + 2); step(); idle();          // B+LAT, CHG on bit 0
        check("same_edge_old", 32'(dout1), 32'h03);
        rd_p1(NREG + 2); step(); idle();
        check("same_edge_kept", 32'(dout1), 32'h01);
        rd_p1(NREG + 2); step(); idle();
        check("flag2_clear", 32'(dout1), 32'h00);

        // Both ports read flag register 7 together
        set_reg(7, 8'h0F);
        repeat (LAT + 3) step();
        rd_p1(NREG + 7); rd_p2(NREG + 7); step(); idle();
        check("dual_flag7_p1", 32'(dout1), 32'h0F);
        check("dual_flag7_p2", 32'(dout2), 32'h0F);
        // Clear on one port while the other reads live 7
        rd_p1(NREG + 7); rd_p2(7); step(); idle();
        check("flag7_after", 32'(dout1), 32'h00);
        check("live7_indep", 32'(dout2), 32'h0F);
        step();
        check("irq_all_clear", 32'(irq), 32'h0);

        // Multi-select OR and all-zero select
        rd_p1(5); sel1[7] = 1'b1; sel1[2] = 1'b1; step(); idle();
        check("or_live", 32'(dout1), 32'hAF);
        cs1 = 1'b1; rd1 = 1'b1; sel1 = '0; step(); idle();
        check("zero_sel", 32'(dout1), 32'h00);

`ifdef GPI_DEBOUNCE_EN
        // Short glitch is filtered, long hold passes
        din[0] = 1'b1;
        repeat (3) step();
        din[0] = 1'b0;
        repeat (12) step();
        rd_p1(NREG + 0); rd_p2(0); step(); idle();
        check("deb_glitch_flag", 32'(dout1), 32'h00);
        check("deb_glitch_live", 32'(dout2), 32'h00);
        din[0] = 1'b1;
        step();                                   // E0
        repeat (LAT - 1) step();
        rd_p2(0); step(); idle();                 // E0+LAT
        check("deb_hold_live", 32'(dout2), 32'h01);
        rd_p1(NREG + 0); step(); idle();
        check("deb_hold_flag", 32'(dout1), 32'h01);
`endif

        // Reset mid-sequence with a flag pending and a read active
        set_reg(9, 8'hFF);
        repeat (LAT + 3) step();
        check("irq_flag9", 32'(irq), 32'h1);
        rd_p2(9); step(); idle();
        check("live9", 32'(dout2), 32'hFF);
        rd_p1(NREG + 9);
        rst_n = 1'b0;
        step(); idle();
        check("rst_mid_dout1", 32'(dout1), 32'h00);
        check("rst_mid_dout2", 32'(dout2), 32'h00);
        check("rst_mid_irq",   32'(irq),   32'h0);
        step();
        rst_n = 1'b1;

        // Inputs held high through reset raise flags after release
        repeat (LAT + 2) step();
        rd_p1(NREG + 9); rd_p2(NREG + 2); step(); idle();
        check("post_rst_flag9", 32'(dout1), 32'hFF);
        check("post_rst_flag2", 32'(dout2), 32'h02);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
